mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM stage of the RV32I pipeline; consumes the EX/MEM register outputs (rd_*, mem_addr/data, mem_we/re, inst).
//  Runs load/store bus transactions on a req/ack data bus, with byte/half lane steering and load sign/zero extension.
//  Registers the write-back result for WB (acts as the MEM/WB register).
//  Raises hold_flag_o to control to freeze upstream stages while a bus access is pending.
// PARAMETERS
//  TIMEOUT  255  max BUS-state cycles without ack_i before abort; counter is 8 bits; 0 disables timeout
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  inst_i         in   32  instruction; funct3 = inst_i[14:12] selects access size/sign
//  rd_addr_i      in   5   dest reg from EX
//  rd_data_i      in   32  EX result (non-memory ops)
//  rd_wen_i       in   1   dest write enable from EX
//  mem_addr_i     in   32  byte address of load/store
//  mem_data_i     in   32  store data (rs2, unaligned in low bits)
//  mem_we_i       in   1   store request
//  mem_re_i       in   1   load request
//  req_o          out  1   data bus request, held until ack_i
//  we_o           out  1   bus write (1) / read (0)
//  addr_o         out  32  word-aligned bus address {mem_addr_i[31:2],2'b00}
//  wdata_o        out  32  lane-replicated store data
//  wstrb_o        out  4   byte strobes
//  rdata_i        in   32  bus read data, valid with ack_i
//  ack_i          in   1   bus completion, one cycle
//  rd_addr_o      out  5   to WB
//  rd_data_o      out  32  to WB
//  rd_wen_o       out  1   to WB
//  hold_flag_o    out  1   stall request to control (combinational)
//  bus_err_o      out  1   one-cycle pulse on timeout abort
//  misalign_o     out  1   one-cycle pulse on misaligned access (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; req_o,we_o,rd_wen_o,bus_err_o,misalign_o=0; addr_o,wdata_o,wstrb_o,rd_data_o=0; rd_addr_o=0; timeout counter=0.
//  States: IDLE, BUS.
//  IDLE, no mem op: next edge rd_*_o <= rd_*_i (1-cycle latency); hold_flag_o=0.
//  IDLE, mem op: hold_flag_o=1; next edge -> BUS with req_o=1, addr_o/we_o/wdata_o/wstrb_o latched; rd_wen_o<=0.
//  mem_we_i && mem_re_i: treated as store; re ignored.
//  Unknown funct3: no bus cycle, rd_wen_o<=0, stay IDLE, hold 0.
//  BUS: req_o and all bus outputs stable until ack_i; hold_flag_o = ~ack_i.
//  ack_i in BUS: next edge req_o<=0, state IDLE. Load: rd_data_o <= extracted data, rd_addr_o <= rd_addr_i, rd_wen_o <= rd_wen_i. Store: rd_wen_o <= 0.
//  Load-to-WB latency: 1 cycle after ack_i (min 2 cycles from op entry).
//  Stores: SB strobe 0001<<a[1:0], data {4{b}}; SH strobe 0011<<{a[1],1'b0}, data {2{h}}; SW 1111, data as-is.
//  Loads: LB/LBU take byte lane a[1:0]; LH/LHU take half lane a[1]; sign-extend (LB,LH) or zero-extend (LBU,LHU); LW whole word.
//  Timeout: counter cleared on BUS entry, +1 per non-ack cycle; reaching TIMEOUT -> req_o<=0, bus_err_o pulse, rd_wen_o<=0, IDLE.
//  ack_i outside BUS: ignored.
//  rst mid-BUS: req_o drops at that edge; pending access is discarded, no WB write.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 issues no bus cycle;
//    next edge misalign_o pulses 1 cycle, rd_wen_o<=0, stays IDLE, hold 0.
//  Not defined: misalign_o=0; low address bits are ignored beyond lane select; access goes to the aligned word/half.
// TESTING
//  ALU pass-through: rd_addr_i=5, rd_data_i=0x1234, rd_wen_i=1, no mem -> next cycle rd_*_o match; hold 0.
//  LB at addr 0x103, rdata=0x80FF_0000, ack 1st BUS cycle -> rd_data_o=0xFFFFFF80; LBU same -> 0x00000080.
//  SH data 0x0000ABCD to addr 0x202 -> addr_o=0x200, wstrb_o=1100, wdata_o=0xABCDABCD, rd_wen_o=0.
//  LW with ack delayed 3 cycles -> req_o high 4 cycles, hold_flag_o high through them, low on ack cycle.
//  No ack, TIMEOUT=4 -> bus_err_o pulse after 4 BUS cycles, req_o=0, no WB write; rst mid-BUS -> req_o=0 next edge.
//  LSU_MISALIGN_TRAP_EN on: LW addr 0x101 -> no req_o, misalign_o 1-cycle pulse; off: addr_o=0x100.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage of the RV32I pipeline.
//   Issues load/store accesses on a req/ack data bus, steers byte/half lanes, sign/zero-extends
//   load data and registers the write-back result for WB (this module is the MEM/WB register).
//   hold_flag_o freezes upstream stages while an access is outstanding.
//
// Parameters
//   TIMEOUT  BUS-state cycles without ack_i before the access is aborted (8-bit counter,
//            0 disables the timeout)
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN)
//   defined   : misaligned half/word accesses issue no bus cycle and pulse misalign_o
//   undefined : misalign_o is 0 and misaligned accesses go to the aligned word/half
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   inst_i                      instruction, funct3 = inst_i[14:12] selects size/sign
//   rd_addr_i/rd_data_i/rd_wen_i  destination register info from EX
//   mem_addr_i/mem_data_i       byte address, store data (unaligned in low bits)
//   mem_we_i/mem_re_i           store/load request (store wins if both set)
//   req_o/we_o/addr_o/wdata_o/wstrb_o  data bus request side, held until ack_i
//   rdata_i/ack_i               data bus response side
//   rd_addr_o/rd_data_o/rd_wen_o  write-back result to WB
//   hold_flag_o                 combinational stall request
//   bus_err_o                   one-cycle pulse on timeout abort
//   misalign_o                  one-cycle pulse on misaligned access
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic [31:0] rdata_i,
  input  logic        ack_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        hold_flag_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);

  // State and registered outputs
  state_e      r_state;
  logic        r_req, r_we, r_rd_wen, r_bus_err, r_misalign;
  logic [31:0] r_addr, r_wdata, r_rd_data;
  logic [3:0]  r_wstrb;
  logic [4:0]  r_rd_addr;
  // Access context captured on BUS entry, used when the ack arrives
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [4:0]  r_ld_rd_addr;
  logic        r_ld_rd_wen;
  logic [7:0]  r_cnt;

  // Next-state values
  state_e      w_state_d;
  logic        w_req_d, w_we_d, w_rd_wen_d, w_bus_err_d, w_misalign_d;
  logic [31:0] w_addr_d, w_wdata_d, w_rd_data_d;
  logic [3:0]  w_wstrb_d;
  logic [4:0]  w_rd_addr_d;
  logic [2:0]  w_f3_d;
  logic [1:0]  w_off_d;
  logic [4:0]  w_ld_rd_addr_d;
  logic        w_ld_rd_wen_d;
  logic [7:0]  w_cnt_d;
  logic        w_hold;

  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic        w_mem_op, w_f3_ok, w_misalign, w_start;
  logic [3:0]  w_st_strb;
  logic [31:0] w_st_data;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic        w_unused_inst;

  assign w_f3          = inst_i[14:12];
  assign w_off         = mem_addr_i[1:0];
  assign w_mem_op      = mem_we_i | mem_re_i;
  assign w_unused_inst = ^{inst_i[31:15], inst_i[11:0]};

  // Stores accept SB/SH/SW; loads accept LB/LH/LW/LBU/LHU
  always_comb begin
    w_f3_ok = 1'b0;
    if (mem_we_i) begin
      w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
    end else begin
      w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                (w_f3 == 3'b100) || (w_f3 == 3'b101);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op && w_f3_ok &&
                      (((w_f3[1:0] == 2'b01) && w_off[0]) ||
                       ((w_f3[1:0] == 2'b10) && (w_off != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = w_mem_op && w_f3_ok && !w_misalign;

  // Store lane steering: replicate the narrow datum across all lanes, strobe picks the lane
  always_comb begin
    w_st_strb = 4'b1111;
    w_st_data = mem_data_i;
    case (w_f3[1:0])
      2'b00: begin
        w_st_strb = 4'b0001 << w_off;
        w_st_data = {4{mem_data_i[7:0]}};
      end
      2'b01: begin
        w_st_strb = 4'b0011 << {w_off[1], 1'b0};
        w_st_data = {2{mem_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction from the captured offset/funct3
  always_comb begin
    w_ld_byte = rdata_i[7:0];
    case (r_off)
      2'd1:    w_ld_byte = rdata_i[15:8];
      2'd2:    w_ld_byte = rdata_i[23:16];
      2'd3:    w_ld_byte = rdata_i[31:24];
      default: w_ld_byte = rdata_i[7:0];
    endcase
    w_ld_half = r_off[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (r_f3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = rdata_i;
    endcase
  end

  // Next-state / output logic
  always_comb begin
    w_state_d      = r_state;
    w_req_d        = r_req;
    w_we_d         = r_we;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_wstrb_d      = r_wstrb;
    w_rd_addr_d    = r_rd_addr;
    w_rd_data_d    = r_rd_data;
    w_rd_wen_d     = r_rd_wen;
    w_bus_err_d    = 1'b0;
    w_misalign_d   = 1'b0;
    w_f3_d         = r_f3;
    w_off_d        = r_off;
    w_ld_rd_addr_d = r_ld_rd_addr;
    w_ld_rd_wen_d  = r_ld_rd_wen;
    w_cnt_d        = r_cnt;
    w_hold         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_hold         = 1'b1;
          w_state_d      = StBus;
          w_req_d        = 1'b1;
          w_we_d         = mem_we_i;
          w_addr_d       = {mem_addr_i[31:2], 2'b00};
          w_wdata_d      = mem_we_i ? w_st_data : 32'd0;
          w_wstrb_d      = mem_we_i ? w_st_strb : 4'd0;
          w_rd_wen_d     = 1'b0;
          w_f3_d         = w_f3;
          w_off_d        = w_off;
          w_ld_rd_addr_d = rd_addr_i;
          w_ld_rd_wen_d  = rd_wen_i;
          w_cnt_d        = 8'd0;
        end else if (w_mem_op) begin
          // Unsupported funct3 or misaligned: drop the access, no write-back
          w_rd_wen_d   = 1'b0;
          w_misalign_d = w_misalign;
        end else begin
          w_rd_addr_d = rd_addr_i;
          w_rd_data_d = rd_data_i;
          w_rd_wen_d  = rd_wen_i;
        end
      end
      StBus: begin
        w_hold = ~ack_i;
        if (ack_i) begin
          w_req_d   = 1'b0;
          w_state_d = StIdle;
          if (!r_we) begin
            w_rd_data_d = w_ld_data;
            w_rd_addr_d = r_ld_rd_addr;
            w_rd_wen_d  = r_ld_rd_wen;
          end else begin
            w_rd_wen_d = 1'b0;
          end
        end else if (TimeoutEn && (r_cnt == TimeoutLast)) begin
          w_req_d     = 1'b0;
          w_bus_err_d = 1'b1;
          w_rd_wen_d  = 1'b0;
          w_state_d   = StIdle;
        end else if (TimeoutEn) begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_rd_addr    <= 5'd0;
      r_rd_data    <= 32'd0;
      r_rd_wen     <= 1'b0;
      r_bus_err    <= 1'b0;
      r_misalign   <= 1'b0;
      r_f3         <= 3'd0;
      r_off        <= 2'd0;
      r_ld_rd_addr <= 5'd0;
      r_ld_rd_wen  <= 1'b0;
      r_cnt        <= 8'd0;
    end else begin
      r_state      <= w_state_d;
      r_req        <= w_req_d;
      r_we         <= w_we_d;
      r_addr       <= w_addr_d;
      r_wdata      <= w_wdata_d;
      r_wstrb      <= w_wstrb_d;
      r_rd_addr    <= w_rd_addr_d;
      r_rd_data    <= w_rd_data_d;
      r_rd_wen     <= w_rd_wen_d;
      r_bus_err    <= w_bus_err_d;
      r_misalign   <= w_misalign_d;
      r_f3         <= w_f3_d;
      r_off        <= w_off_d;
      r_ld_rd_addr <= w_ld_rd_addr_d;
      r_ld_rd_wen  <= w_ld_rd_wen_d;
      r_cnt        <= w_cnt_d;
    end
  end

  assign req_o       = r_req;
  assign we_o        = r_we;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign wstrb_o     = r_wstrb;
  assign rd_addr_o   = r_rd_addr;
  assign rd_data_o   = r_rd_data;
  assign rd_wen_o    = r_rd_wen;
  assign hold_flag_o = w_hold;
  assign bus_err_o   = r_bus_err;
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, rd_data_i, mem_addr_i, mem_data_i, rdata_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i, mem_we_i, mem_re_i, ack_i;
  logic        req_o, we_o, rd_wen_o, hold_flag_o, bus_err_o, misalign_o;
  logic [31:0] addr_o, wdata_o, rd_data_o;
  logic [3:0]  wstrb_o;
  logic [4:0]  rd_addr_o;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_i     (inst_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .rd_wen_i   (rd_wen_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_we_i   (mem_we_i),
    .mem_re_i   (mem_re_i),
    .req_o      (req_o),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .wstrb_o    (wstrb_o),
    .rdata_i    (rdata_i),
    .ack_i      (ack_i),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .rd_wen_o   (rd_wen_o),
    .hold_flag_o(hold_flag_o),
    .bus_err_o  (bus_err_o),
    .misalign_o (misalign_o)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit f3_valid(input bit st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    int unsigned bytes = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 1;
    return (a % bytes) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned off = a % 4;
    int unsigned b   = (rd >> (8 * off)) & 32'hFF;
    int unsigned h   = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. Called and returns on a negative edge.
  // delay = non-ack BUS cycles before ack; delay >= TO means the access times out.
  task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input logic wen,
                       input int delay, input logic [31:0] rdata);
    logic [31:0] ins;
    bit st, mem, go, acked;
    ins        = $urandom;
    ins[14:12] = f3;
    inst_i     = ins;
    rd_addr_i  = rd;
    rd_wen_i   = wen;
    rd_data_i  = (kind == 0) ? d : $urandom;
    mem_addr_i = a;
    mem_data_i = d;
    mem_we_i   = (kind == 2);
    mem_re_i   = (kind == 1) || ((kind == 2) && ($urandom_range(0, 1) == 1));
    ack_i      = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;  // stray ack is ignored
    rdata_i    = $urandom;
    st  = (kind == 2);
    mem = (kind != 0);
    go  = mem && f3_valid(st, f3) && !is_mis(f3, a);
    #1;
    chk("hold_idle", 32'(hold_flag_o), 32'(go));
    if (!mem) begin
      @(negedge clk);
      ack_i = 1'b0;
      chk("alu_rd_addr", 32'(rd_addr_o), 32'(rd));
      chk("alu_rd_data", rd_data_o, d);
      chk("alu_rd_wen", 32'(rd_wen_o), 32'(wen));
      chk("alu_req", 32'(req_o), 0);
      chk("alu_bus_err", 32'(bus_err_o), 0);
    end else if (!go) begin
      @(negedge clk);
      chk("drop_rd_wen", 32'(rd_wen_o), 0);
      chk("drop_req", 32'(req_o), 0);
      chk("drop_misalign", 32'(misalign_o), 32'(is_mis(f3, a)));
    end else begin
      @(negedge clk);
      chk("bus_req", 32'(req_o), 1);
      chk("bus_we", 32'(we_o), 32'(st));
      chk("bus_addr", addr_o, a & 32'hFFFF_FFFC);
      chk("bus_rd_wen", 32'(rd_wen_o), 0);
      chk("bus_misalign", 32'(misalign_o), 0);
      if (st) begin
        chk("bus_wstrb", 32'(wstrb_o), 32'(st_strb(f3, a)));
        chk("bus_wdata", wdata_o, st_data(f3, d));
      end
      acked = (delay + 1) <= int'(TO);
      for (int k = 1; k <= int'(TO); k++) begin
        ack_i   = (k == delay + 1);
        rdata_i = ack_i ? rdata : $urandom;
        #1;
        chk("bus_hold", 32'(hold_flag_o), 32'(!ack_i));
        chk("bus_req_held", 32'(req_o), 1);
        chk("bus_addr_held", addr_o, a & 32'hFFFF_FFFC);
        @(negedge clk);
        if (ack_i) break;
      end
      ack_i = 1'b0;
      chk("end_req", 32'(req_o), 0);
      chk("end_bus_err", 32'(bus_err_o), 32'(!acked));
      if (acked && !st) begin
        chk("ld_rd_wen", 32'(rd_wen_o), 32'(wen));
        chk("ld_rd_addr", 32'(rd_addr_o), 32'(rd));
        chk("ld_rd_data", rd_data_o, load_val(f3, a, rdata));
      end else begin
        chk("end_rd_wen", 32'(rd_wen_o), 0);
      end
    end
  endtask

  task automatic idle_inputs();
    inst_i = '0; rd_addr_i = '0; rd_data_i = '0; rd_wen_i = 1'b0;
    mem_addr_i = '0; mem_data_i = '0; mem_we_i = 1'b0; mem_re_i = 1'b0;
    rdata_i = '0; ack_i = 1'b0;
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(req_o), 0);
    chk("rst_we", 32'(we_o), 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wstrb", 32'(wstrb_o), 0);
    chk("rst_rd_addr", 32'(rd_addr_o), 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rd_wen", 32'(rd_wen_o), 0);
    chk("rst_bus_err", 32'(bus_err_o), 0);
    chk("rst_misalign", 32'(misalign_o), 0);
    chk("rst_hold", 32'(hold_flag_o), 0);
    rst = 1'b0;

    // Directed cases
    do_op(0, 3'd0, 32'h0, 32'h1234, 5'd5, 1'b1, 0, 0);                // ALU pass-through
    do_op(1, 3'd0, 32'h103, 32'h0, 5'd7, 1'b1, 0, 32'h80FF_0000);     // LB  -> FFFFFF80
    do_op(1, 3'd4, 32'h103, 32'h0, 5'd8, 1'b1, 0, 32'h80FF_0000);     // LBU -> 00000080
    do_op(2, 3'd1, 32'h202, 32'h0000_ABCD, 5'd3, 1'b1, 0, 0);         // SH lanes 3:2
    do_op(1, 3'd2, 32'h100, 32'h0, 5'd9, 1'b1, 3, 32'hDEAD_BEEF);     // LW, ack on 4th cycle
    do_op(1, 3'd2, 32'h100, 32'h0, 5'd9, 1'b1, 10, 32'h0);            // timeout abort
    do_op(0, 3'd0, 32'h0, 32'hCAFE_0001, 5'd1, 1'b0, 0, 0);           // bus_err pulse gone
    do_op(1, 3'd2, 32'h101, 32'h0, 5'd4, 1'b1, 0, 32'h1122_3344);     // misaligned LW
    do_op(1, 3'd5, 32'h303, 32'h0, 5'd6, 1'b1, 1, 32'h8765_4321);     // LHU upper half
    do_op(1, 3'd1, 32'h302, 32'h0, 5'd6, 1'b1, 2, 32'h8765_4321);     // LH sign-extend
    do_op(1, 3'd3, 32'h100, 32'h0, 5'd2, 1'b1, 0, 0);                 // unknown load f3
    do_op(2, 3'd4, 32'h100, 32'h55, 5'd2, 1'b1, 0, 0);                // unknown store f3

    // Reset while a load is pending: request drops, no write-back
    do_op(0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0);
    inst_i = 32'h0000_2003; mem_addr_i = 32'h400; mem_re_i = 1'b1;
    rd_addr_i = 5'd10; rd_wen_i = 1'b1;
    @(negedge clk);
    chk("rstbus_req_up", 32'(req_o), 1);
    rst = 1'b1; mem_re_i = 1'b0; rd_wen_i = 1'b0;
    @(negedge clk);
    chk("rstbus_req", 32'(req_o), 0);
    chk("rstbus_rd_wen", 32'(rd_wen_o), 0);
    chk("rstbus_hold", 32'(hold_flag_o), 0);
    rst = 1'b0; ack_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    ack_i = 1'b0;
    chk("rstbus_no_wb", 32'(rd_wen_o), 0);
    chk("rstbus_req_idle", 32'(req_o), 0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      f3   = f3_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      do_op(kind, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
            $urandom_range(0, 5), $urandom);
    end

    idle_inputs();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
